// File: rtl/hazard_forward_ctrl.sv
// Forwarding-select and load-use hazard control for the MIPS EX stage.
// Optional saturating stall counter is enabled with `define HAZARD_STALL_COUNT_EN.
module hazard_forward_ctrl #(
  parameter int NB_REG        = 5,
  parameter int CORTOCIRCUITO = 3,
  parameter int NB_CNT        = 16
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_enable,
  input  logic                     i_id_valid,
  input  logic [NB_REG-1:0]        i_id_rs,
  input  logic [NB_REG-1:0]        i_id_rt,
  input  logic                     i_id_use_rs,
  input  logic                     i_id_use_rt,
  input  logic                     i_id_reg_write,
  input  logic                     i_id_mem_read,
  input  logic [NB_REG-1:0]        i_id_rd,
  input  logic                     i_flush,
  output logic [CORTOCIRCUITO-1:0] o_fwd_a,
  output logic [CORTOCIRCUITO-1:0] o_fwd_b,
  output logic                     o_stall,
  output logic [NB_CNT-1:0]        o_stall_count
);

  typedef enum logic {S_RUN, S_STALL} state_e;

  localparam logic [CORTOCIRCUITO-1:0] FWD_REG   = CORTOCIRCUITO'(0);
  localparam logic [CORTOCIRCUITO-1:0] FWD_EXMEM = CORTOCIRCUITO'(1);
  localparam logic [CORTOCIRCUITO-1:0] FWD_MEMWB = CORTOCIRCUITO'(2);

  state_e state_q, state_d;

  logic              ex_valid_q, ex_valid_d;
  logic              ex_reg_write_q, ex_reg_write_d;
  logic              ex_mem_read_q, ex_mem_read_d;
  logic [NB_REG-1:0] ex_rd_q, ex_rd_d;
  logic              mem_valid_q, mem_valid_d;
  logic              mem_reg_write_q, mem_reg_write_d;
  logic [NB_REG-1:0] mem_rd_q, mem_rd_d;
  logic [CORTOCIRCUITO-1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;

  logic ex_writer, mem_writer, hazard, bubble;

  // WB-distance hazards are resolved by register-file write-before-read,
  // so only the EX and MEM shadows influence any decision here.
  assign ex_writer  = ex_valid_q & ex_reg_write_q & (ex_rd_q != '0);
  assign mem_writer = mem_valid_q & mem_reg_write_q & (mem_rd_q != '0);
  assign hazard     = i_id_valid & ex_writer & ex_mem_read_q &
                      ((i_id_use_rs & (i_id_rs == ex_rd_q)) |
                       (i_id_use_rt & (i_id_rt == ex_rd_q)));
  assign bubble     = o_stall | i_flush | ~i_id_valid;

  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= S_RUN;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (i_enable) begin
      case (state_q)
        S_RUN:   if (o_stall) state_d = S_STALL;
        S_STALL: state_d = S_RUN;
        default: state_d = S_RUN;
      endcase
    end
  end

  always_comb begin
    o_stall = hazard & ~i_flush & (state_q == S_RUN);
  end

  always_comb begin
    ex_valid_d      = ex_valid_q;
    ex_reg_write_d  = ex_reg_write_q;
    ex_mem_read_d   = ex_mem_read_q;
    ex_rd_d         = ex_rd_q;
    mem_valid_d     = mem_valid_q;
    mem_reg_write_d = mem_reg_write_q;
    mem_rd_d        = mem_rd_q;
    fwd_a_d         = fwd_a_q;
    fwd_b_d         = fwd_b_q;
    if (i_enable) begin
      mem_valid_d     = ex_valid_q;
      mem_reg_write_d = ex_reg_write_q;
      mem_rd_d        = ex_rd_q;
      ex_valid_d      = ~bubble;
      ex_reg_write_d  = i_id_reg_write;
      ex_mem_read_d   = i_id_mem_read;
      ex_rd_d         = i_id_rd;
      fwd_a_d         = FWD_REG;
      fwd_b_d         = FWD_REG;
      if (!bubble) begin
        if (i_id_use_rs && ex_writer && (i_id_rs == ex_rd_q))        fwd_a_d = FWD_EXMEM;
        else if (i_id_use_rs && mem_writer && (i_id_rs == mem_rd_q)) fwd_a_d = FWD_MEMWB;
        if (i_id_use_rt && ex_writer && (i_id_rt == ex_rd_q))        fwd_b_d = FWD_EXMEM;
        else if (i_id_use_rt && mem_writer && (i_id_rt == mem_rd_q)) fwd_b_d = FWD_MEMWB;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ex_valid_q      <= 1'b0;
      ex_reg_write_q  <= 1'b0;
      ex_mem_read_q   <= 1'b0;
      ex_rd_q         <= '0;
      mem_valid_q     <= 1'b0;
      mem_reg_write_q <= 1'b0;
      mem_rd_q        <= '0;
      fwd_a_q         <= '0;
      fwd_b_q         <= '0;
    end else begin
      ex_valid_q      <= ex_valid_d;
      ex_reg_write_q  <= ex_reg_write_d;
      ex_mem_read_q   <= ex_mem_read_d;
      ex_rd_q         <= ex_rd_d;
      mem_valid_q     <= mem_valid_d;
      mem_reg_write_q <= mem_reg_write_d;
      mem_rd_q        <= mem_rd_d;
      fwd_a_q         <= fwd_a_d;
      fwd_b_q         <= fwd_b_d;
    end
  end

  assign o_fwd_a = fwd_a_q;
  assign o_fwd_b = fwd_b_q;

`ifdef HAZARD_STALL_COUNT_EN
  logic [NB_CNT-1:0] stall_count_q, stall_count_d;

  always_comb begin
    stall_count_d = stall_count_q;
    if (i_enable && o_stall && (stall_count_q != '1))
      stall_count_d = stall_count_q + NB_CNT'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) stall_count_q <= '0;
    else         stall_count_q <= stall_count_d;
  end

  assign o_stall_count = stall_count_q;
`else
  assign o_stall_count = '0;
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed self-checking bench for hazard_forward_ctrl.
module tb_hazard_forward_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b1;
  logic        id_valid = 1'b0;
  logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0;
  logic        use_rs = 1'b0, use_rt = 1'b0, reg_write = 1'b0, mem_read = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  fwd_a, fwd_b;
  logic        stall;
  logic [15:0] stall_count;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

`ifdef HAZARD_STALL_COUNT_EN
  localparam logic [15:0] CNT_ONE = 16'd1;
`else
  localparam logic [15:0] CNT_ONE = 16'd0;
`endif

  hazard_forward_ctrl #(.NB_REG(5), .CORTOCIRCUITO(3), .NB_CNT(16)) dut (
    .i_clk(clk), .i_reset(rst), .i_enable(en), .i_id_valid(id_valid),
    .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_use_rs(use_rs), .i_id_use_rt(use_rt),
    .i_id_reg_write(reg_write), .i_id_mem_read(mem_read), .i_id_rd(id_rd),
    .i_flush(flush), .o_fwd_a(fwd_a), .o_fwd_b(fwd_b), .o_stall(stall),
    .o_stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic urs,
                       input logic [4:0] rt, input logic urt,
                       input logic rw, input logic mr, input logic [4:0] rd,
                       input logic fl);
    id_valid = v; id_rs = rs; use_rs = urs; id_rt = rt; use_rt = urt;
    reg_write = rw; mem_read = mr; id_rd = rd; flush = fl;
    #1;
  endtask

  initial begin
    // Reset held two cycles
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("rst_fwd_a", 16'(fwd_a), 16'd0);
    check("rst_fwd_b", 16'(fwd_b), 16'd0);
    check("rst_stall", 16'(stall), 16'd0);
    check("rst_count", stall_count, 16'd0);

    // EX/MEM forward: add $3 then sub rs=3
    drive(1, 5'd1, 1, 5'd2, 1, 1, 0, 5'd3, 0); tick();
    drive(1, 5'd3, 1, 5'd9, 1, 1, 0, 5'd4, 0);
    check("exmem_nostall", 16'(stall), 16'd0);
    tick();
    check("exmem_fwd_a", 16'(fwd_a), 16'd1);
    check("exmem_fwd_b", 16'(fwd_b), 16'd0);

    // MEM/WB forward: add $3, unrelated, or rt=3
    drive(1, 5'd1, 1, 5'd2, 1, 1, 0, 5'd3, 0); tick();
    drive(1, 5'd1, 1, 5'd2, 1, 1, 0, 5'd7, 0); tick();
    drive(1, 5'd0, 0, 5'd3, 1, 1, 0, 5'd8, 0); tick();
    check("memwb_fwd_b", 16'(fwd_b), 16'd2);
    check("memwb_fwd_a", 16'(fwd_a), 16'd0);

    // Priority: EX.rd=3 and MEM.rd=3 both live
    drive(1, 5'd1, 1, 5'd2, 1, 1, 0, 5'd3, 0); tick();
    drive(1, 5'd1, 1, 5'd2, 1, 1, 0, 5'd3, 0); tick();
    drive(1, 5'd3, 1, 5'd3, 1, 1, 0, 5'd8, 0); tick();
    check("prio_fwd_a", 16'(fwd_a), 16'd1);
    check("prio_fwd_b", 16'(fwd_b), 16'd1);

    // Load-use: lw $5, add rs=5
    drive(1, 5'd1, 1, 5'd0, 0, 1, 1, 5'd5, 0); tick();
    drive(1, 5'd5, 1, 5'd2, 1, 1, 0, 5'd6, 0);
    check("lu_stall", 16'(stall), 16'd1);
    tick();
    check("lu_bubble_a", 16'(fwd_a), 16'd0);
    check("lu_bubble_b", 16'(fwd_b), 16'd0);
    check("lu_stall_once", 16'(stall), 16'd0);
    check("lu_count", stall_count, CNT_ONE);
    tick();
    check("lu_after_fwd_a", 16'(fwd_a), 16'd2);
    check("lu_after_fwd_b", 16'(fwd_b), 16'd0);

    // Load-use coinciding with flush
    drive(1, 5'd1, 1, 5'd0, 0, 1, 1, 5'd5, 0); tick();
    drive(1, 5'd5, 1, 5'd2, 1, 1, 0, 5'd6, 1);
    check("fl_nostall", 16'(stall), 16'd0);
    tick();
    check("fl_bubble_a", 16'(fwd_a), 16'd0);
    drive(1, 5'd5, 1, 5'd2, 1, 1, 0, 5'd6, 0);
    check("fl_no_late_stall", 16'(stall), 16'd0);
    tick();
    check("fl_count", stall_count, CNT_ONE);

    // rd = 0 never forwards or stalls
    drive(1, 5'd1, 1, 5'd2, 1, 1, 1, 5'd0, 0); tick();
    drive(1, 5'd0, 1, 5'd0, 1, 1, 0, 5'd9, 0);
    check("rd0_nostall", 16'(stall), 16'd0);
    tick();
    check("rd0_fwd_a", 16'(fwd_a), 16'd0);
    check("rd0_fwd_b", 16'(fwd_b), 16'd0);

    // Enable low for three cycles holds state
    drive(1, 5'd1, 1, 5'd2, 1, 1, 0, 5'd3, 0); tick();
    drive(1, 5'd3, 1, 5'd2, 1, 1, 0, 5'd4, 0); tick();
    check("en_pre_fwd_a", 16'(fwd_a), 16'd1);
    drive(1, 5'd1, 1, 5'd3, 1, 1, 0, 5'd8, 0);
    en = 1'b0;
    tick(); tick(); tick();
    check("en_hold_a", 16'(fwd_a), 16'd1);
    check("en_hold_b", 16'(fwd_b), 16'd0);
    en = 1'b1;
    tick();
    check("en_resume_a", 16'(fwd_a), 16'd0);
    check("en_resume_b", 16'(fwd_b), 16'd2);

    // Reset asserted in the stall cycle
    drive(1, 5'd1, 1, 5'd0, 0, 1, 1, 5'd5, 0); tick();
    drive(1, 5'd5, 1, 5'd2, 1, 1, 0, 5'd6, 0);
    check("rs_stall", 16'(stall), 16'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("rs_nostall", 16'(stall), 16'd0);
    check("rs_fwd_a", 16'(fwd_a), 16'd0);
    check("rs_fwd_b", 16'(fwd_b), 16'd0);
    check("rs_count", stall_count, 16'd0);
    tick();
    check("rs_post_fwd_a", 16'(fwd_a), 16'd0);
    check("rs_post_stall", 16'(stall), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
